// File: rtl/atmega_tim_pkg.sv
// Shared constants for the ATmega timer prescaler: GTCCR bit positions,
// prescaler tap widths and the common counter width.
package atmega_tim_pkg;

  localparam int CNT_W = 10;

  localparam int GTCCR_TSM     = 7;
  localparam int GTCCR_PSRASY  = 1;
  localparam int GTCCR_PSRSYNC = 0;

  localparam int TAP_8    = 3;
  localparam int TAP_32   = 5;
  localparam int TAP_64   = 6;
  localparam int TAP_128  = 7;
  localparam int TAP_256  = 8;
  localparam int TAP_1024 = 10;

  // True when the low `width` bits of the counter are all ones.
  function automatic logic tap_hit(input logic [CNT_W-1:0] cnt, input int width);
    logic [CNT_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < CNT_W; i++) begin
      if (i < width) mask[i] = 1'b1;
    end
    return (cnt & mask) == mask;
  endfunction

endpackage

// File: rtl/atmega_tim_pin_sync.sv
// Three-flop synchroniser for an external timer clock pin, followed by
// registered single-cycle rise/fall pulses.
module atmega_tim_pin_sync (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q, rise_q, fall_q;
  logic s1_d, s2_d, s3_d, rise_d, fall_d;

  always_comb begin
    s1_d   = pin;
    s2_d   = s1_q;
    s3_d   = s2_q;
    rise_d = s2_q & ~s3_q;
    fall_d = ~s2_q & s3_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/atmega_tim_prescaler.sv
// Shared prescaler for the ATmega timers: sync and timer-2 counters with tick
// strobes, the GTCCR register, and the T0/T1 external clock front end.
module atmega_tim_prescaler
  import atmega_tim_pkg::*;
#(
  parameter int BUS_ADDR_DATA_LEN = 8,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] GTCCR_ADDR = 'h43
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         halt,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr_dat,
  input  logic                         wr_dat,
  input  logic                         rd_dat,
  input  logic [7:0]                   bus_dat_in,
  output logic [7:0]                   bus_dat_out,
  output logic                         clk8,
  output logic                         clk64,
  output logic                         clk256,
  output logic                         clk1024,
  output logic                         clk2_8,
  output logic                         clk2_32,
  output logic                         clk2_64,
  output logic                         clk2_128,
  output logic                         clk2_256,
  output logic                         clk2_1024,
  input  logic                         t0,
  input  logic                         t1,
  output logic                         t0_rise,
  output logic                         t0_fall,
  output logic                         t1_rise,
  output logic                         t1_fall
);

  logic [CNT_W-1:0] psc_sync_q, psc_sync_d;
  logic [CNT_W-1:0] psc_asy_q, psc_asy_d;
  logic             tsm_q, tsm_d;
  logic             psrsync_q, psrsync_d;
  logic             psrasy_q, psrasy_d;

  logic gtccr_sel, gtccr_wr;
  logic sync_hold, asy_hold, sync_clr, asy_clr;
  logic sync_go, asy_go;
  logic unused_bits;

  assign gtccr_sel = (addr_dat == GTCCR_ADDR);
  assign gtccr_wr  = wr_dat & gtccr_sel;

  // Hold state is taken from the registered bits, so a write that sets
  // TSM and PSRx together clears the counter now and holds from next cycle.
  assign sync_hold = tsm_q & psrsync_q;
  assign asy_hold  = tsm_q & psrasy_q;
  assign sync_clr  = (gtccr_wr & bus_dat_in[GTCCR_PSRSYNC]) | sync_hold;
  assign asy_clr   = (gtccr_wr & bus_dat_in[GTCCR_PSRASY]) | asy_hold;

  always_comb begin
    tsm_d     = tsm_q;
    psrsync_d = psrsync_q & tsm_q;
    psrasy_d  = psrasy_q & tsm_q;
    if (gtccr_wr) begin
      tsm_d     = bus_dat_in[GTCCR_TSM];
      psrsync_d = bus_dat_in[GTCCR_TSM] & (bus_dat_in[GTCCR_PSRSYNC] | psrsync_q);
      psrasy_d  = bus_dat_in[GTCCR_TSM] & (bus_dat_in[GTCCR_PSRASY] | psrasy_q);
    end
  end

  always_comb begin
    psc_sync_d = psc_sync_q + 1'b1;
    if (sync_clr)  psc_sync_d = '0;
    else if (halt) psc_sync_d = psc_sync_q;

    psc_asy_d = psc_asy_q + 1'b1;
    if (asy_clr)   psc_asy_d = '0;
    else if (halt) psc_asy_d = psc_asy_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_sync_q <= '0;
      psc_asy_q  <= '0;
      tsm_q      <= 1'b0;
      psrsync_q  <= 1'b0;
      psrasy_q   <= 1'b0;
    end else begin
      psc_sync_q <= psc_sync_d;
      psc_asy_q  <= psc_asy_d;
      tsm_q      <= tsm_d;
      psrsync_q  <= psrsync_d;
      psrasy_q   <= psrasy_d;
    end
  end

  assign sync_go = ~halt & ~sync_hold;
  assign asy_go  = ~halt & ~asy_hold;

  assign clk8    = sync_go & tap_hit(psc_sync_q, TAP_8);
  assign clk64   = sync_go & tap_hit(psc_sync_q, TAP_64);
  assign clk256  = sync_go & tap_hit(psc_sync_q, TAP_256);
  assign clk1024 = sync_go & tap_hit(psc_sync_q, TAP_1024);

  assign clk2_8    = asy_go & tap_hit(psc_asy_q, TAP_8);
  assign clk2_32   = asy_go & tap_hit(psc_asy_q, TAP_32);
  assign clk2_64   = asy_go & tap_hit(psc_asy_q, TAP_64);
  assign clk2_128  = asy_go & tap_hit(psc_asy_q, TAP_128);
  assign clk2_256  = asy_go & tap_hit(psc_asy_q, TAP_256);
  assign clk2_1024 = asy_go & tap_hit(psc_asy_q, TAP_1024);

  always_comb begin
    bus_dat_out = 8'h00;
    if (rd_dat && gtccr_sel) begin
      bus_dat_out[GTCCR_TSM]     = tsm_q;
      bus_dat_out[GTCCR_PSRASY]  = psrasy_q;
      bus_dat_out[GTCCR_PSRSYNC] = psrsync_q;
    end
  end

  // Write data on GTCCR bits 6:2 is discarded; those bits read 0.
  assign unused_bits = ^bus_dat_in[6:2];

  atmega_tim_pin_sync u_t0_sync (
    .clk  (clk),
    .rst  (rst),
    .pin  (t0),
    .rise (t0_rise),
    .fall (t0_fall)
  );

  atmega_tim_pin_sync u_t1_sync (
    .clk  (clk),
    .rst  (rst),
    .pin  (t1),
    .rise (t1_rise),
    .fall (t1_fall)
  );

endmodule

// File: tb/tb_atmega_tim_prescaler.sv
// Directed bench for atmega_tim_prescaler: free run, PSR clear, TSM hold,
// halt, pin edge detection and GTCCR bus access.
module tb_atmega_tim_prescaler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       halt = 1'b0;
  logic [7:0] addr_dat = 8'h00;
  logic       wr_dat = 1'b0;
  logic       rd_dat = 1'b0;
  logic [7:0] bus_dat_in = 8'h00;
  logic [7:0] bus_dat_out;
  logic       clk8, clk64, clk256, clk1024;
  logic       clk2_8, clk2_32, clk2_64, clk2_128, clk2_256, clk2_1024;
  logic       t0 = 1'b0;
  logic       t1 = 1'b0;
  logic       t0_rise, t0_fall, t1_rise, t1_fall;

  int n_checks = 0;
  int n_errors = 0;
  int e = 0;

  atmega_tim_prescaler #(
    .BUS_ADDR_DATA_LEN (8),
    .GTCCR_ADDR        (8'h43)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .halt        (halt),
    .addr_dat    (addr_dat),
    .wr_dat      (wr_dat),
    .rd_dat      (rd_dat),
    .bus_dat_in  (bus_dat_in),
    .bus_dat_out (bus_dat_out),
    .clk8        (clk8),
    .clk64       (clk64),
    .clk256      (clk256),
    .clk1024     (clk1024),
    .clk2_8      (clk2_8),
    .clk2_32     (clk2_32),
    .clk2_64     (clk2_64),
    .clk2_128    (clk2_128),
    .clk2_256    (clk2_256),
    .clk2_1024   (clk2_1024),
    .t0          (t0),
    .t1          (t1),
    .t0_rise     (t0_rise),
    .t0_fall     (t0_fall),
    .t1_rise     (t1_rise),
    .t1_fall     (t1_fall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, act, exp, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    e = 0;
  endtask

  task automatic gtccr_write(input logic [7:0] d);
    addr_dat   = 8'h43;
    bus_dat_in = d;
    wr_dat     = 1'b1;
    step();
    wr_dat   = 1'b0;
    addr_dat = 8'h00;
  endtask

  task automatic gtccr_read(output logic [7:0] v);
    addr_dat = 8'h43;
    rd_dat   = 1'b1;
    #1;
    v = bus_dat_out;
    rd_dat   = 1'b0;
    addr_dat = 8'h00;
  endtask

  function automatic logic [15:0] sync_vec();
    return {12'h000, clk1024, clk256, clk64, clk8};
  endfunction

  function automatic logic [15:0] asy_vec();
    return {10'h000, clk2_1024, clk2_256, clk2_128, clk2_64, clk2_32, clk2_8};
  endfunction

  // d = edges since the counter was last at 0
  function automatic logic [15:0] exp_sync(input int d);
    return {12'h000, d % 1024 == 1023, d % 256 == 255, d % 64 == 63, d % 8 == 7};
  endfunction

  function automatic logic [15:0] exp_asy(input int d);
    return {10'h000, d % 1024 == 1023, d % 256 == 255, d % 128 == 127,
            d % 64 == 63, d % 32 == 31, d % 8 == 7};
  endfunction

  initial begin
    logic [7:0] rv;
    int k;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_sync", sync_vec(), 16'h0000);
    check("rst_asy", asy_vec(), 16'h0000);
    check("rst_pins", {12'h000, t0_rise, t0_fall, t1_rise, t1_fall}, 16'h0000);
    gtccr_read(rv);
    check("rst_gtccr", {8'h00, rv}, 16'h0000);
    check("rst_cnt", {6'h00, dut.psc_sync_q}, 16'h0000);

    // Free run with a t0 pulse
    rst = 1'b0;
    e = 0;
    for (int n = 1; n <= 2048; n++) begin
      if (n == 50) t0 = 1'b1;
      if (n == 60) t0 = 1'b0;
      step();
      check("run_sync", sync_vec(), exp_sync(e));
      check("run_asy", asy_vec(), exp_asy(e));
      check("t0_edges", {14'h0000, t0_rise, t0_fall}, {14'h0000, e == 52, e == 62});
      check("t1_idle", {14'h0000, t1_rise, t1_fall}, 16'h0000);
    end

    // PSRSYNC clear at edge 100, plus combinational halt gating at edge 7
    do_reset();
    for (int n = 1; n <= 99; n++) begin
      step();
      if (e == 7) begin
        check("pre_halt_clk8", {15'h0000, clk8}, 16'h0001);
        halt = 1'b1;
        #1;
        check("halt_gate_clk8", {15'h0000, clk8}, 16'h0000);
        halt = 1'b0;
        #1;
        check("halt_ungate_clk8", {15'h0000, clk8}, 16'h0001);
      end
    end
    gtccr_write(8'h01);
    check("psr_cnt_zero", {6'h00, dut.psc_sync_q}, 16'h0000);
    gtccr_read(rv);
    check("psr_selfclr", {8'h00, rv}, 16'h0000);
    for (int n = 0; n < 80; n++) begin
      step();
      check("psr_sync", sync_vec(), exp_sync(e - 100));
      check("psr_asy", asy_vec(), exp_asy(e));
    end

    // TSM hold of both prescalers, then release
    gtccr_write(8'h83);
    gtccr_read(rv);
    check("hold_gtccr", {8'h00, rv}, 16'h0083);
    for (int n = 1; n <= 500; n++) begin
      step();
      check("hold_sync", sync_vec(), 16'h0000);
      check("hold_asy", asy_vec(), 16'h0000);
      if (n % 100 == 0) begin
        gtccr_read(rv);
        check("hold_gtccr_mid", {8'h00, rv}, 16'h0083);
      end
    end
    gtccr_write(8'h00);
    k = e;
    gtccr_read(rv);
    check("release_gtccr", {8'h00, rv}, 16'h0000);
    for (int n = 0; n < 80; n++) begin
      step();
      check("release_sync", sync_vec(), exp_sync(e - k));
      check("release_asy", asy_vec(), exp_asy(e - k));
    end

    // Bus decode and write-all-ones
    gtccr_write(8'hFF);
    addr_dat = 8'h44;
    rd_dat   = 1'b1;
    #1;
    check("rd_wrong_addr", {8'h00, bus_dat_out}, 16'h0000);
    addr_dat = 8'h43;
    rd_dat   = 1'b0;
    #1;
    check("rd_no_strobe", {8'h00, bus_dat_out}, 16'h0000);
    rd_dat = 1'b1;
    #1;
    check("rd_ff", {8'h00, bus_dat_out}, 16'h0083);
    rd_dat   = 1'b0;
    addr_dat = 8'h00;
    for (int n = 0; n < 16; n++) begin
      step();
      check("ff_hold_sync", sync_vec(), 16'h0000);
      check("ff_hold_asy", asy_vec(), 16'h0000);
    end
    gtccr_write(8'h00);

    // Halt for 20 cycles starting at edge 5; t1 held high through reset
    t1 = 1'b1;
    do_reset();
    for (int n = 1; n <= 4; n++) begin
      step();
      check("t1_rst_rise", {14'h0000, t1_rise, t1_fall}, {14'h0000, e == 3, 1'b0});
    end
    halt = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step();
      check("halt_sync", sync_vec(), 16'h0000);
      check("halt_asy", asy_vec(), 16'h0000);
      check("halt_t1", {14'h0000, t1_rise, t1_fall}, 16'h0000);
    end
    check("halt_cnt_kept", {6'h00, dut.psc_sync_q}, 16'h0004);
    halt = 1'b0;
    for (int n = 0; n < 80; n++) begin
      step();
      check("post_halt_sync", sync_vec(), exp_sync(e - 20));
      check("post_halt_asy", asy_vec(), exp_asy(e - 20));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/atmega_tim_prescaler.md
# atmega_tim_prescaler

Shared prescaler and external-clock front end for the ATmega timer set. Two free-running 10-bit counters, one for the synchronous timers (0/1) and one for timer 2, generate single-cycle tick strobes. These strobes are the `clk8`…`clk1024` inputs of the 8-bit and 16-bit timers. The block owns the GTCCR register (TSM / PSRASY / PSRSYNC) and synchronises the T0/T1 external-clock pins into rise/fall tick pulses for the timers' external-clock mux slots.

## Interface
Parameters:
- `BUS_ADDR_DATA_LEN`, 8, I/O address width.
- `GTCCR_ADDR`, 'h43, GTCCR data-space address.

Ports:
- `clk`  in  1  core I/O clock.
- `rst`  in  1  synchronous, active-high reset.
- `halt`  in  1  debug halt; freezes both counters and forces all strobes low.
- `addr_dat`  in  BUS_ADDR_DATA_LEN  bus address.
- `wr_dat`  in  1  write strobe.
- `rd_dat`  in  1  read strobe.
- `bus_dat_in`  in  8  write data.
- `bus_dat_out`  out  8  read data, combinational; 0 when not selected.
- `clk8`, `clk64`, `clk256`, `clk1024`  out  1 each  sync-prescaler tick strobes.
- `clk2_8`, `clk2_32`, `clk2_64`, `clk2_128`, `clk2_256`, `clk2_1024`  out  1 each  timer-2 prescaler tick strobes.
- `t0`, `t1`  in  1 each  asynchronous external clock pins.
- `t0_rise`, `t0_fall`, `t1_rise`, `t1_fall`  out  1 each  registered single-cycle edge pulses.

## Operation
- `psc_sync[9:0]` and `psc_asy[9:0]` increment by 1 each clk, wrapping 1023→0, unless `halt` or their hold/clear applies.
- Strobe decode: tick N = (low log2(N) bits of its counter all ones) & ~halt & ~hold. Result: exactly one high cycle per N clocks, never two consecutive cycles.
- GTCCR read value is {TSM, 5'b0, PSRASY, PSRSYNC}. Bits 6:2 ignore writes and read 0.
- Writing PSRSYNC=1: `psc_sync` loads 0 at that edge.
  - TSM=0 after the write: PSRSYNC self-clears and reads 0.
  - TSM=1 after the write: PSRSYNC stays 1, `psc_sync` is held at 0 and its strobes are forced low (hold).
- PSRASY behaves identically for `psc_asy`.
- Writing TSM=0: PSRSYNC and PSRASY clear at the same edge. Counters resume from 0 on the next edge.
- A single write setting TSM=1 and PSRSYNC=1 enters hold at that edge.
- Priority on each counter: rst > PSRx clear/hold > halt > increment.
- Pin path, per pin: s1←pin, s2←s1, s3←s2. Then rise_r ← s2&~s3 and fall_r ← ~s2&s3.
  - Pins are not gated by halt or TSM.
- Pin flops reset to 0. A pin held high through reset yields one `rise` pulse after release.

## Timing
- Reset values: counters 0, GTCCR 0, all strobes 0, all pin flops 0, all edge pulses 0, `bus_dat_out` 0.
- Counting from the first rising edge with rst low (edge 1):
  - `clk8` is high in the cycle after edge 7; the consumer samples it at edge 8.
  - `clk64` follows after edge 63; `clk1024` after edge 1023; then every N cycles.
- Prescaler reset via PSRx with TSM=0 at edge k: the next `clk8` is high after edge k+7, and the next `clkN` after edge k+N−1.
- Release of hold (TSM written 0 at edge k): the first tick N is high after edge k+N−1.
- Pin latency: a level first captured by s1 at edge k gives `rise`/`fall` high for exactly one cycle after edge k+2.
  - Pulses shorter than one clk period may be lost.
  - Minimum detectable pin period: 2 clk cycles high and 2 clk cycles low.
- `halt` asserted at edge k: counters keep their value and strobes drop immediately (combinational). Counting resumes with no lost or duplicated ticks.

## Structure
- Shared package `atmega_tim_pkg`:
  - GTCCR bit positions: TSM=7, PSRASY=1, PSRSYNC=0.
  - Prescaler tap widths: 3, 5, 6, 7, 8, 10.
  - Counter width: 10.
- Sub-module `atmega_tim_pin_sync`: 3-flop synchroniser plus registered rise/fall detector. Instantiated once each for t0 and t1.
- Both prescaler counters and the GTCCR register stay in the top module.

## Test plan
- Reset release, free run of 2048 cycles → `clk8` after edges 7, 15, 23…; `clk1024` after edges 1023 and 2047; `clk2_32` after edges 31, 63…; every strobe exactly 1 cycle wide.
- At cycle 100 write GTCCR=8'h01 → `psc_sync` equals 0 after that edge; `clk8` next high after edge 107; GTCCR reads 8'h00; `psc_asy` strobes unaffected.
- Write 8'h83, idle 500 cycles, then write 8'h00 → all strobes stay low during hold and GTCCR reads 8'h83; after the release at edge k, `clk8` is high after edge k+7 and `clk2_8` after edge k+7.
- Assert `halt` for 20 cycles at cycle 5 → no strobes during halt; the first `clk8` lands 20 cycles later than in the free run (after edge 27).
- Drive t0 0→1 captured at edge 50, then 1→0 captured at edge 60 → `t0_rise` high only after edge 52; `t0_fall` high only after edge 62; `t1_*` stay 0.
- Read with `addr_dat`≠`GTCCR_ADDR` or `rd_dat`=0 → `bus_dat_out`=8'h00; write 8'hFF → reads 8'h83, and since TSM=1 both PSR bits stay set.
